// File: rtl/led_debug_viewer_pkg.sv
// Shared definitions for the LED debug viewer: mode encodings and
// constant/index helpers used by the viewer and its scan prescaler.
package debug_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Ceiling log2 for elaboration-time width computation; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Requested slice indices past the last slice land on the last slice.
    function automatic int unsigned clamp_index(input int unsigned req,
                                                input int unsigned nslice);
        return (req < nslice) ? req : nslice - 32'd1;
    endfunction

    // Bit offset of a slice inside the zero-padded snapshot.
    function automatic int unsigned slice_lsb(input int unsigned index,
                                              input int unsigned led_w);
        return index * led_w;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divides clk down to the auto-scan step rate; tick marks the terminal count
// and is only ever high while en is high.
module scan_prescaler
    import debug_pkg::*;
#(
    parameter int DIV = 25000000,
    localparam int CNT_W = (DIV > 1) ? clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_r;

    // Free-running divider that parks at zero whenever scanning is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (!en || (count_r == LAST)) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign tick = en && (count_r == LAST);

endmodule

// File: rtl/led_debug_viewer.sv
// Snapshots one of NUM_CH debug words and shows one LED_W-bit slice of it,
// chosen manually or by a prescaled auto-scan.
module led_debug_viewer
    import debug_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LED_W    = 8,
    parameter int NUM_CH   = 2,
    parameter int SCAN_DIV = 25000000,
    localparam int NSLICE  = (DATA_W + LED_W - 1) / LED_W,
    localparam int SEL_W   = (NSLICE > 1) ? clog2(NSLICE) : 1,
    localparam int CH_W    = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         man_sel,
    input  logic                     freeze,
    output logic [LED_W-1:0]         LED,
    output logic [SEL_W-1:0]         idx_o,
    output logic                     frozen_o,
    output logic                     scan_tick
);

    localparam int PAD_W = NSLICE * LED_W;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NSLICE - 1);

    logic [CH_W-1:0]   chan_s;
    logic [DATA_W-1:0] word_s;
    logic [PAD_W-1:0]  padded_s;
    logic              tick_s;
    logic [DATA_W-1:0] snap_r;
    logic [SEL_W-1:0]  idx_r;

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (mode == MODE_AUTO),
        .tick (tick_s)
    );

    // Out-of-range channel requests fall back to channel 0.
    always_comb begin
        chan_s = '0;
        if (32'(ch_sel) < NUM_CH) begin
            chan_s = ch_sel;
        end else begin
            chan_s = '0;
        end
        word_s = data_in[chan_s*DATA_W +: DATA_W];
    end

    // Zero-extend the snapshot so the top slice may be only partly populated.
    always_comb begin
        padded_s = '0;
        padded_s[DATA_W-1:0] = snap_r;
    end

    // Snapshot, slice index and display registers; rst overrides all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_r    <= '0;
            idx_r     <= '0;
            LED       <= '0;
            idx_o     <= '0;
            frozen_o  <= 1'b0;
            scan_tick <= 1'b0;
        end else begin
            frozen_o <= freeze;
            if (!freeze) begin
                snap_r <= word_s;
            end else begin
                snap_r <= snap_r;
            end
            case (mode)
                MODE_MANUAL: idx_r <= SEL_W'(clamp_index(32'(man_sel), NSLICE));
                MODE_AUTO: begin
                    if (tick_s) begin
                        idx_r <= (idx_r == SEL_LAST) ? '0 : idx_r + SEL_W'(1);
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: idx_r <= idx_r;
            endcase
            scan_tick <= tick_s;
            LED       <= padded_s[slice_lsb(32'(idx_r), LED_W) +: LED_W];
            idx_o     <= idx_r;
        end
    end

endmodule

// File: tb/tb_led_debug_viewer.sv
// Bench for led_debug_viewer: three configurations driven in parallel,
// checked each cycle against a cycle-counting model plus literal expectations.
module tb_led_debug_viewer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mode, freeze;
    logic [1:0] man_sel;

    logic [63:0] data_a;  logic       ch_sel_a;  logic [7:0] led_a;  logic [1:0] idx_a;  logic frz_a, tick_a;
    logic [95:0] data_b;  logic [1:0] ch_sel_b;  logic [7:0] led_b;  logic [1:0] idx_b;  logic frz_b, tick_b;
    logic [39:0] data_c;  logic       ch_sel_c;  logic [7:0] led_c;  logic [1:0] idx_c;  logic frz_c, tick_c;

    led_debug_viewer #(.DATA_W(32), .LED_W(8), .NUM_CH(2), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .ch_sel(ch_sel_a), .mode(mode),
        .man_sel(man_sel), .freeze(freeze), .LED(led_a), .idx_o(idx_a),
        .frozen_o(frz_a), .scan_tick(tick_a));

    led_debug_viewer #(.DATA_W(32), .LED_W(8), .NUM_CH(3), .SCAN_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .ch_sel(ch_sel_b), .mode(mode),
        .man_sel(man_sel), .freeze(freeze), .LED(led_b), .idx_o(idx_b),
        .frozen_o(frz_b), .scan_tick(tick_b));

    led_debug_viewer #(.DATA_W(20), .LED_W(8), .NUM_CH(2), .SCAN_DIV(4)) dut_c (
        .clk(clk), .rst(rst), .data_in(data_c), .ch_sel(ch_sel_c), .mode(mode),
        .man_sel(man_sel), .freeze(freeze), .LED(led_c), .idx_o(idx_c),
        .frozen_o(frz_c), .scan_tick(tick_c));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: word selected for configuration k, masked to its data width.
    function automatic logic [31:0] sel_word(input int k);
        logic [95:0] all;
        logic [95:0] sh;
        int ch, dw, nch;
        case (k)
            0:       begin all = {32'd0, data_a}; ch = int'(ch_sel_a); dw = 32; nch = 2; end
            1:       begin all = data_b;          ch = int'(ch_sel_b); dw = 32; nch = 3; end
            default: begin all = {56'd0, data_c}; ch = int'(ch_sel_c); dw = 20; nch = 2; end
        endcase
        if (ch >= nch) ch = 0;
        sh = all >> (ch * dw);
        return (dw == 32) ? sh[31:0] : (sh[31:0] & ((32'd1 << dw) - 32'd1));
    endfunction

    function automatic int nslice(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    logic [31:0] m_snap [3];
    int          m_idx  [3];
    logic [7:0]  m_led  [3];
    int          m_idxo [3];
    int          m_run;
    logic        m_frz, m_tick;

    // Model state: m_run counts consecutive auto cycles; every 4th steps the scan.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_snap[k] <= 32'd0; m_idx[k] <= 0; m_led[k] <= 8'd0; m_idxo[k] <= 0;
            end
            m_run <= 0; m_frz <= 1'b0; m_tick <= 1'b0;
        end else begin
            m_frz  <= freeze;
            m_run  <= mode ? m_run + 1 : 0;
            m_tick <= mode && (((m_run + 1) % 4) == 0);
            for (int k = 0; k < 3; k++) begin
                m_led[k]  <= 8'(m_snap[k] >> (8 * m_idx[k]));
                m_idxo[k] <= m_idx[k];
                if (!freeze) m_snap[k] <= sel_word(k);
                if (!mode)
                    m_idx[k] <= (int'(man_sel) < nslice(k)) ? int'(man_sel) : nslice(k) - 1;
                else if (((m_run + 1) % 4) == 0)
                    m_idx[k] <= (m_idx[k] + 1) % nslice(k);
            end
        end
    end

    // Compare every DUT output with the model once per cycle, away from posedge.
    always @(negedge clk) begin
        chk("a_led",  32'(led_a),  32'(m_led[0]));
        chk("a_idx",  32'(idx_a),  32'(m_idxo[0]));
        chk("a_frz",  32'(frz_a),  32'(m_frz));
        chk("a_tick", 32'(tick_a), 32'(m_tick));
        chk("b_led",  32'(led_b),  32'(m_led[1]));
        chk("b_idx",  32'(idx_b),  32'(m_idxo[1]));
        chk("b_frz",  32'(frz_b),  32'(m_frz));
        chk("b_tick", 32'(tick_b), 32'(m_tick));
        chk("c_led",  32'(led_c),  32'(m_led[2]));
        chk("c_idx",  32'(idx_c),  32'(m_idxo[2]));
        chk("c_frz",  32'(frz_c),  32'(m_frz));
        chk("c_tick", 32'(tick_c), 32'(m_tick));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] sweep [4];
        sweep = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        rst = 1'b1; mode = 1'b0; freeze = 1'b0; man_sel = 2'd0;
        ch_sel_a = 1'b0; ch_sel_b = 2'd0; ch_sel_c = 1'b0;
        data_a = {32'hCAFEF00D, 32'h12345678};
        data_b = {32'h99AABBCC, 32'h55667788, 32'h12345678};
        data_c = {20'h13579, 20'hABCDE};

        step(2);
        chk("lit_rst_led",  32'(led_a),  32'h00);
        chk("lit_rst_idx",  32'(idx_a),  32'd0);
        chk("lit_rst_frz",  32'(frz_a),  32'd0);
        chk("lit_rst_tick", 32'(tick_a), 32'd0);
        rst = 1'b0;
        step(2);
        chk("lit_release_led", 32'(led_a), 32'h78);

        data_a[31:0] = 32'hDEADBEEF;
        for (int s = 0; s < 4; s++) begin
            man_sel = 2'(s);
            step(2);
            chk("lit_sweep_led", 32'(led_a), 32'(sweep[s]));
            step(1);
        end

        ch_sel_a = 1'b1; ch_sel_b = 2'd1; man_sel = 2'd3;
        step(2);
        chk("lit_ch1_led_a", 32'(led_a), 32'hCA);
        chk("lit_ch1_led_b", 32'(led_b), 32'h55);
        ch_sel_b = 2'd3;
        step(2);
        chk("lit_ch_oor_led_b", 32'(led_b), 32'h12);

        ch_sel_a = 1'b0; data_a[31:0] = 32'h11223344;
        step(1);
        freeze = 1'b1; data_a[31:0] = 32'hAABBCCDD; man_sel = 2'd2;
        step(2);
        chk("lit_freeze_led", 32'(led_a), 32'h22);
        chk("lit_freeze_frz", 32'(frz_a), 32'd1);
        freeze = 1'b0;
        step(2);
        chk("lit_unfreeze_led", 32'(led_a), 32'hBB);

        data_a[31:0] = 32'h04030201; man_sel = 2'd0;
        step(2);
        chk("lit_auto0_led_a", 32'(led_a), 32'h01);
        chk("lit_auto0_led_c", 32'(led_c), 32'hDE);
        mode = 1'b1;
        step(3);
        chk("lit_auto_notick", 32'(tick_a), 32'd0);
        step(1);
        chk("lit_auto_tick", 32'(tick_a), 32'd1);
        step(1);
        chk("lit_auto1_led_a", 32'(led_a), 32'h02);
        chk("lit_auto1_idx_a", 32'(idx_a), 32'd1);
        chk("lit_auto1_led_c", 32'(led_c), 32'hBC);
        step(4);
        chk("lit_auto2_led_a", 32'(led_a), 32'h03);
        chk("lit_auto2_led_c", 32'(led_c), 32'h0A);
        step(4);
        chk("lit_auto3_led_a", 32'(led_a), 32'h04);
        chk("lit_auto_wrap_c", 32'(led_c), 32'hDE);
        step(4);
        chk("lit_auto_wrap_a", 32'(led_a), 32'h01);

        step(2);
        rst = 1'b1;
        step(1);
        chk("lit_midrst_led", 32'(led_a), 32'h00);
        chk("lit_midrst_idx", 32'(idx_a), 32'd0);
        rst = 1'b0;
        step(3);
        mode = 1'b0; man_sel = 2'd1;
        step(1);
        chk("lit_leave_notick", 32'(tick_a), 32'd0);
        step(1);
        chk("lit_leave_idx", 32'(idx_a), 32'd1);

        man_sel = 2'd3;
        step(2);
        chk("lit_clamp_idx_c", 32'(idx_c), 32'd2);
        chk("lit_clamp_led_c", 32'(led_c), 32'h0A);
        chk("lit_noclamp_led_a", 32'(led_a), 32'h04);

        freeze = 1'b1; mode = 1'b1; data_c[19:0] = 20'h55555;
        step(12);
        freeze = 1'b0;
        step(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
